// File: rtl/image_frame_buffer_pp.sv
// Ping-pong 1-bpp frame buffer: word-serial fill bank, flattened read bank, explicit release.
// Optional IMG_BUF_PAD_CHECK_EN adds a sticky pad_err flag for nonzero padding bits.
module image_frame_buffer_pp #(
  parameter int IMG_WIDTH  = 30,
  parameter int IMG_HEIGHT = 30,
  parameter int DATA_W     = 8,
  localparam int TOTAL_BITS = IMG_WIDTH * IMG_HEIGHT,
  localparam int WORDS      = (TOTAL_BITS + DATA_W - 1) / DATA_W,
  localparam int AW         = $clog2(WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_buffer,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [AW-1:0]         write_addr,
  output logic                  buffer_full,
  output logic                  buffer_empty,
  output logic                  frame_valid,
  input  logic                  frame_release,
  output logic                  rd_bank,
`ifdef IMG_BUF_PAD_CHECK_EN
  output logic                  pad_err,
`endif
  output logic [TOTAL_BITS-1:0] img_out
);

  localparam int IW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int REM = TOTAL_BITS % DATA_W;

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic          wr_en, last_word, rel_en;

  // Storage is deliberately unreset; only the pointers define validity.
  logic [WORDS-1:0][DATA_W-1:0] mem [2];
  logic [WORDS*DATA_W-1:0]      rd_flat;

  always_comb begin
    s_ready     = !bank_full_q[wr_bank_q];
    frame_valid = bank_full_q[rd_bank_q];
    wr_en       = s_valid && s_ready && !clear_buffer;
    last_word   = (wr_cnt_q == AW'(WORDS - 1));
    rel_en      = frame_release && frame_valid && !clear_buffer;

    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    bank_full_d = bank_full_q;

    if (clear_buffer) begin
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
      wr_cnt_d    = '0;
      bank_full_d = '0;
    end else begin
      // A write and a release can never target the same bank, so both apply.
      if (wr_en) begin
        if (last_word) begin
          bank_full_d[wr_bank_q] = 1'b1;
          wr_bank_d              = !wr_bank_q;
          wr_cnt_d               = '0;
        end else begin
          wr_cnt_d = wr_cnt_q + AW'(1);
        end
      end
      if (rel_en) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      bank_full_q <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      bank_full_q <= bank_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank_q][wr_cnt_q[IW-1:0]] <= s_data;
  end

`ifdef IMG_BUF_PAD_CHECK_EN
  logic pad_err_q, pad_err_d, pad_hit;

  always_comb begin
    pad_hit = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (REM != 0 && i >= REM) pad_hit = pad_hit | s_data[i];
    pad_err_d = pad_err_q;
    if (clear_buffer)                      pad_err_d = 1'b0;
    else if (wr_en && last_word && pad_hit) pad_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pad_err_q <= 1'b0;
    else        pad_err_q <= pad_err_d;
  end

  assign pad_err = pad_err_q;
`endif

  assign rd_flat      = mem[rd_bank_q];
  assign img_out      = rd_flat[TOTAL_BITS-1:0];
  assign rd_bank      = rd_bank_q;
  assign write_addr   = wr_cnt_q;
  assign buffer_full  = &bank_full_q;
  assign buffer_empty = (bank_full_q == 2'b00) && (wr_cnt_q == '0);

endmodule

// File: tb/tb_image_frame_buffer_pp.sv
// Directed bench for image_frame_buffer_pp at default geometry (30x30, 8-bit words, 113 words/frame).
module tb_image_frame_buffer_pp;

  localparam int TB = 900;
  localparam int AW = 7;

  logic          clk, rst_n, clear_buffer, s_valid, s_ready, frame_release, rd_bank;
  logic [7:0]    s_data;
  logic [AW-1:0] write_addr;
  logic          buffer_full, buffer_empty, frame_valid;
  logic [TB-1:0] img_out;
`ifdef IMG_BUF_PAD_CHECK_EN
  logic          pad_err;
`endif

  int vecs = 0;
  int errs = 0;

  image_frame_buffer_pp dut (
    .clk(clk), .rst_n(rst_n), .clear_buffer(clear_buffer),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .write_addr(write_addr), .buffer_full(buffer_full), .buffer_empty(buffer_empty),
    .frame_valid(frame_valid), .frame_release(frame_release), .rd_bank(rd_bank),
`ifdef IMG_BUF_PAD_CHECK_EN
    .pad_err(pad_err),
`endif
    .img_out(img_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 0; s_data = 0; frame_release = 0; clear_buffer = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  // n words, value base+i when incr else constant base; s_valid held high throughout
  task automatic send(input int n, input logic [7:0] base, input bit incr);
    for (int i = 0; i < n; i++) begin
      s_valid = 1;
      s_data  = incr ? base + 8'(i) : base;
      tick();
    end
    s_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (s_ready !== 1'b1) begin errs++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    vecs++; if (frame_valid !== 1'b0) begin errs++; $display("FAIL reset_frame_valid got %b want 0", frame_valid); end
    vecs++; if (buffer_full !== 1'b0) begin errs++; $display("FAIL reset_buffer_full got %b want 0", buffer_full); end
    vecs++; if (buffer_empty !== 1'b1) begin errs++; $display("FAIL reset_buffer_empty got %b want 1", buffer_empty); end
    vecs++; if (write_addr !== 7'd0 || rd_bank !== 1'b0) begin errs++; $display("FAIL reset_ptrs got addr=%0d rd=%b want 0/0", write_addr, rd_bank); end
  endtask

  task automatic test_stream();
    do_reset();
    send(112, 8'h00, 1);
    vecs++; if (frame_valid !== 1'b0 || write_addr !== 7'd112) begin errs++; $display("FAIL stream_pre got fv=%b addr=%0d want 0/112", frame_valid, write_addr); end
    vecs++; if (buffer_empty !== 1'b0) begin errs++; $display("FAIL stream_pre_empty got %b want 0", buffer_empty); end
    send(1, 8'h70, 0);
    vecs++; if (frame_valid !== 1'b1) begin errs++; $display("FAIL stream_fv got %b want 1", frame_valid); end
    vecs++; if (write_addr !== 7'd0 || rd_bank !== 1'b0) begin errs++; $display("FAIL stream_ptrs got addr=%0d rd=%b want 0/0", write_addr, rd_bank); end
    vecs++; if (img_out[7:0] !== 8'h00 || img_out[15:8] !== 8'h01) begin errs++; $display("FAIL stream_low got %h want 0100", img_out[15:0]); end
    vecs++; if (img_out[895:888] !== 8'h6F) begin errs++; $display("FAIL stream_w111 got %h want 6f", img_out[895:888]); end
    vecs++; if (img_out[899:896] !== 4'h0) begin errs++; $display("FAIL stream_last_nibble got %h want 0", img_out[899:896]); end
    vecs++; if (img_out[407:400] !== 8'h32) begin errs++; $display("FAIL stream_w50 got %h want 32", img_out[407:400]); end
    vecs++; if (s_ready !== 1'b1 || buffer_full !== 1'b0) begin errs++; $display("FAIL stream_status got rdy=%b full=%b want 1/0", s_ready, buffer_full); end
  endtask

  task automatic test_backpressure();
    logic [TB-1:0] snap;
    do_reset();
    send(113, 8'hFF, 0);
    send(113, 8'hAA, 0);
    vecs++; if (buffer_full !== 1'b1 || s_ready !== 1'b0) begin errs++; $display("FAIL bp_full got full=%b rdy=%b want 1/0", buffer_full, s_ready); end
    vecs++; if (img_out[7:0] !== 8'hFF || img_out[899:896] !== 4'hF) begin errs++; $display("FAIL bp_bank0 got %h/%h want ff/f", img_out[7:0], img_out[899:896]); end
    snap = img_out;
    send(1, 8'h12, 0);
    vecs++; if (write_addr !== 7'd0 || buffer_full !== 1'b1) begin errs++; $display("FAIL bp_ignored got addr=%0d full=%b want 0/1", write_addr, buffer_full); end
    vecs++; if (img_out !== snap) begin errs++; $display("FAIL bp_img_stable got %h want %h", img_out[31:0], snap[31:0]); end
    frame_release = 1; tick(); frame_release = 0;
    vecs++; if (rd_bank !== 1'b1 || frame_valid !== 1'b1) begin errs++; $display("FAIL bp_rel got rd=%b fv=%b want 1/1", rd_bank, frame_valid); end
    vecs++; if (img_out[7:0] !== 8'hAA || img_out[899:896] !== 4'hA) begin errs++; $display("FAIL bp_bank1 got %h/%h want aa/a", img_out[7:0], img_out[899:896]); end
    vecs++; if (s_ready !== 1'b1 || buffer_full !== 1'b0) begin errs++; $display("FAIL bp_ready got rdy=%b full=%b want 1/0", s_ready, buffer_full); end
  endtask

  task automatic test_simul();
    do_reset();
    send(113, 8'h55, 0);
    send(112, 8'h33, 0);
    s_valid = 1; s_data = 8'h33; frame_release = 1;
    tick();
    s_valid = 0; frame_release = 0;
    vecs++; if (frame_valid !== 1'b1 || rd_bank !== 1'b1) begin errs++; $display("FAIL simul_fv got fv=%b rd=%b want 1/1", frame_valid, rd_bank); end
    vecs++; if (buffer_full !== 1'b0 || s_ready !== 1'b1) begin errs++; $display("FAIL simul_banks got full=%b rdy=%b want 0/1", buffer_full, s_ready); end
    vecs++; if (img_out[7:0] !== 8'h33 || img_out[899:896] !== 4'h3) begin errs++; $display("FAIL simul_img got %h/%h want 33/3", img_out[7:0], img_out[899:896]); end
    vecs++; if (write_addr !== 7'd0 || buffer_empty !== 1'b0) begin errs++; $display("FAIL simul_addr got addr=%0d empty=%b want 0/0", write_addr, buffer_empty); end
  endtask

  task automatic test_clear();
    do_reset();
    send(50, 8'hC3, 0);
    vecs++; if (write_addr !== 7'd50) begin errs++; $display("FAIL clr_pre got %0d want 50", write_addr); end
    s_valid = 1; s_data = 8'h99; clear_buffer = 1;
    tick();
    s_valid = 0; clear_buffer = 0;
    vecs++; if (write_addr !== 7'd0 || buffer_empty !== 1'b1 || frame_valid !== 1'b0) begin errs++; $display("FAIL clr_state got addr=%0d empty=%b fv=%b want 0/1/0", write_addr, buffer_empty, frame_valid); end
    send(113, 8'h3C, 0);
    vecs++; if (frame_valid !== 1'b1 || rd_bank !== 1'b0) begin errs++; $display("FAIL clr_refill got fv=%b rd=%b want 1/0", frame_valid, rd_bank); end
    vecs++; if (img_out[7:0] !== 8'h3C || img_out[407:400] !== 8'h3C || img_out[415:408] !== 8'h3C) begin errs++; $display("FAIL clr_img got %h/%h/%h want 3c", img_out[7:0], img_out[407:400], img_out[415:408]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send(113, 8'h11, 0);
    send(60, 8'h22, 0);
    vecs++; if (write_addr !== 7'd60 || frame_valid !== 1'b1) begin errs++; $display("FAIL ar_pre got addr=%0d fv=%b want 60/1", write_addr, frame_valid); end
    #2 rst_n = 0;
    #1;
    vecs++; if (write_addr !== 7'd0 || frame_valid !== 1'b0 || s_ready !== 1'b1) begin errs++; $display("FAIL ar_now got addr=%0d fv=%b rdy=%b want 0/0/1", write_addr, frame_valid, s_ready); end
    vecs++; if (buffer_empty !== 1'b1 || buffer_full !== 1'b0 || rd_bank !== 1'b0) begin errs++; $display("FAIL ar_status got empty=%b full=%b rd=%b want 1/0/0", buffer_empty, buffer_full, rd_bank); end
    tick();
    rst_n = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      frame_release = 1; tick(); frame_release = 0; tick();
    end
    vecs++; if (rd_bank !== 1'b0 || frame_valid !== 1'b0 || buffer_empty !== 1'b1) begin errs++; $display("FAIL ar_rel_ignored got rd=%b fv=%b empty=%b want 0/0/1", rd_bank, frame_valid, buffer_empty); end
  endtask

`ifdef IMG_BUF_PAD_CHECK_EN
  task automatic test_pad();
    do_reset();
    send(112, 8'h00, 0);
    vecs++; if (pad_err !== 1'b0) begin errs++; $display("FAIL pad_pre got %b want 0", pad_err); end
    send(1, 8'h10, 0);
    vecs++; if (pad_err !== 1'b1) begin errs++; $display("FAIL pad_set got %b want 1", pad_err); end
    frame_release = 1; tick(); frame_release = 0;
    send(112, 8'hFF, 0);
    send(1, 8'h0F, 0);
    vecs++; if (pad_err !== 1'b1) begin errs++; $display("FAIL pad_sticky got %b want 1", pad_err); end
    clear_buffer = 1; tick(); clear_buffer = 0;
    vecs++; if (pad_err !== 1'b0) begin errs++; $display("FAIL pad_clear got %b want 0", pad_err); end
    send(112, 8'hFF, 0);
    send(1, 8'h0F, 0);
    vecs++; if (pad_err !== 1'b0 || frame_valid !== 1'b1) begin errs++; $display("FAIL pad_clean got err=%b fv=%b want 0/1", pad_err, frame_valid); end
  endtask
`endif

  initial begin
    rst_n = 0; s_valid = 0; s_data = 0; frame_release = 0; clear_buffer = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_simul();
    test_clear();
    test_async_reset();
`ifdef IMG_BUF_PAD_CHECK_EN
    test_pad();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/image_frame_buffer_pp.md
Name: image_frame_buffer_pp

Overview:
- Parametrised, double-banked (ping-pong) image frame buffer.
- Word-serial pixel data, e.g. from the SPI/UART byte receiver, is written into the fill bank. A completed frame is presented as a flattened bit vector to the BNN inference core.
- The next frame can stream in while the core is still consuming the current one.
- The core explicitly releases each frame when it is done with it.

Parameters:
- IMG_WIDTH, 30, image width in pixels (1 bit per pixel).
- IMG_HEIGHT, 30, image height in pixels.
- DATA_W, 8, input word width in bits.
- TOTAL_BITS (localparam), IMG_WIDTH*IMG_HEIGHT, flattened pixel count.
- WORDS (localparam), ceil(TOTAL_BITS/DATA_W), words per frame (113 at defaults).
- AW (localparam), $clog2(WORDS+1), address/count width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_buffer  in  1  synchronous flush of both banks and all pointers.
- s_data  in  DATA_W  input pixel word; word k carries pixels k*DATA_W .. k*DATA_W+DATA_W-1, LSB first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  buffer can accept a word this cycle.
- write_addr  out  AW  word index of the next write within the fill bank.
- buffer_full  out  1  both banks hold complete, unreleased frames.
- buffer_empty  out  1  no complete frame and fill count == 0.
- frame_valid  out  1  img_out holds a complete frame.
- frame_release  in  1  consumer done with the current frame.
- rd_bank  out  1  bank index currently driven on img_out.
- img_out  out  TOTAL_BITS  flattened frame; pixel i = img_out[i].

Behaviour:
- Reset values:
  - wr_bank=0, rd_bank=0, wr_cnt=0, bank_full=2'b00.
  - s_ready=1, frame_valid=0, buffer_full=0, buffer_empty=1, write_addr=0.
  - Storage is not reset; img_out is don't-care while frame_valid=0.
- Write handshake:
  - s_ready = !bank_full[wr_bank].
  - A word is accepted on any edge with s_valid && s_ready; it is stored at bank[wr_bank][wr_cnt] and wr_cnt increments.
  - When s_valid=0 or s_ready=0 there is no state change.
- Frame completion: when the accepted word has wr_cnt==WORDS-1, the following all happen on that edge:
  - bank_full[wr_bank] is set.
  - wr_bank toggles.
  - wr_cnt returns to 0.
- Frame latency:
  - frame_valid = bank_full[rd_bank]; img_out = bank[rd_bank][TOTAL_BITS-1:0].
  - Both are registered-state derived, so they are valid in the cycle after the edge that accepted the last word.
- Padding: bits of the last word at or above TOTAL_BITS are stored but never appear on img_out (4 bits at defaults).
- Release:
  - frame_release with frame_valid=1 clears bank_full[rd_bank] and toggles rd_bank on that edge.
  - frame_release with frame_valid=0 is ignored.
  - frame_release must be a single-cycle pulse per frame. A level held high releases one frame per cycle.
- Back-pressure: when both banks are full, s_ready=0 and buffer_full=1. s_ready rises in the cycle after the release edge.
- Simultaneous last-write and release:
  - These are always on different banks, and both take effect.
  - Example: with bank A full and reading, bank B's last word accepted on the same edge as release gives bank_full={B:1, A:0}, rd_bank=B, frame_valid stays 1 with new contents.
- clear_buffer:
  - Has priority over write and release in the same cycle.
  - Sets wr_cnt=0, bank_full=0, wr_bank=0, rd_bank=0.
  - A partial frame is discarded; storage contents are untouched.
- Status outputs: write_addr=wr_cnt; buffer_full = &bank_full; buffer_empty = (bank_full==0) && (wr_cnt==0).
- Reset mid-frame: asynchronous return to the reset state; the partial frame is lost.
- Widths: wr_cnt never exceeds WORDS-1; no wrap beyond WORDS.

Optional Feature:
- Macro: IMG_BUF_PAD_CHECK_EN.
- Defined:
  - Adds output pad_err (1 bit).
  - Set on the edge accepting word WORDS-1 if any padding bit (index >= TOTAL_BITS mod DATA_W within that word) is 1.
  - Sticky until clear_buffer or reset.
  - Always 0 when TOTAL_BITS is a multiple of DATA_W.
- Not defined: no pad_err port; padding bits are silently ignored.

Test Plan:
- Reset, then stream 113 words 0x00..0x70 with s_valid held high -> frame_valid=1 one cycle after the 113th accept; img_out[7:0]=0x00, img_out[903:896] absent, img_out[899:896]=0x0 (low nibble of 0x70); write_addr back to 0; rd_bank=0.
- Fill bank 0 with 0xFF words and bank 1 with 0xAA words, no release -> buffer_full=1, s_ready=0, a further s_valid is ignored (write_addr stays 0); release -> img_out switches to the 0xAA pattern, rd_bank=1, s_ready=1 next cycle.
- Fill bank 0, write 112 words of bank 1, then apply last word and frame_release on the same edge -> frame_valid stays 1, rd_bank=1, bank_full=2'b10, buffer_full=0.
- Write 50 words, assert clear_buffer together with s_valid -> write_addr=0, buffer_empty=1, word not stored; a fresh 113-word frame completes normally.
- Assert rst_n=0 asynchronously mid-frame (between clock edges) at write_addr=60 -> all outputs immediately at reset values; frame_release pulses while frame_valid=0 have no effect.
- With IMG_BUF_PAD_CHECK_EN defined, last word 0x10 (padding bit 4 set) -> pad_err=1 after that edge and held until clear_buffer; last word 0x0F -> pad_err stays 0.
